// File: rtl/hsv2rgb_pipe.sv
// Streaming HSV-to-RGB converter: 3-stage valid/ready pipeline with a sideband tag.
// Define HSV2RGB_PIPE_HUE_WRAP_EN to wrap sextants > 5 modulo 6 instead of clamping to 5.
module hsv2rgb_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned USER_W = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W+7:0]        in_h,
    input  logic [W-1:0]        in_s,
    input  logic [W-1:0]        in_v,
    input  logic [USER_W-1:0]   in_user,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3*W-1:0]      out_rgb,
    output logic [USER_W-1:0]   out_user
);

    localparam int unsigned TW = 2 * W;
    localparam int unsigned MW = 3 * W;
    localparam logic [TW-1:0] K = {{W{1'b1}}, {W{1'b0}}};

    logic advance;

    // Stage 1 state
    logic              vld1_q;
    logic [2:0]        sx1_q;
    logic [TW-1:0]     sf1_q, sfc1_q;
    logic [W-1:0]      val1_q;
    logic              grey1_q;
    logic [USER_W-1:0] user1_q;

    // Stage 2 state
    logic              vld2_q;
    logic [2:0]        sx2_q;
    logic [MW-1:0]     md2_q, mu2_q;
    logic [W-1:0]      val2_q;
    logic              grey2_q;
    logic [USER_W-1:0] user2_q;

    // Stage 3 state
    logic              vld3_q;
    logic [MW-1:0]     rgb3_q;
    logic [USER_W-1:0] user3_q;

    assign advance   = !vld3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld3_q;
    assign out_rgb   = rgb3_q;
    assign out_user  = user3_q;

    // Stage 1 combinational
    logic [7:0]    sext;
    logic [W-1:0]  frac;
    logic [W:0]    frac_c;
    logic [2:0]    sx_d;
    logic [TW-1:0] sf_d, sfc_d;

    always_comb begin
        sext   = in_h[W+7:W];
        frac   = in_h[W-1:0];
        frac_c = {1'b1, {W{1'b0}}} - {1'b0, frac};
`ifdef HSV2RGB_PIPE_HUE_WRAP_EN
        sx_d = 3'(sext % 8'd6);
`else
        sx_d = (sext > 8'd5) ? 3'd5 : sext[2:0];
`endif
        sf_d  = TW'(in_s) * TW'(frac);
        sfc_d = TW'(in_s) * TW'(frac_c);
    end

    // Stage 2 combinational
    logic [TW-1:0] td, tu;
    logic [MW-1:0] md_d, mu_d;

    always_comb begin
        td   = K - sf1_q;
        tu   = K - sfc1_q;
        md_d = MW'(val1_q) * MW'(td);
        mu_d = MW'(val1_q) * MW'(tu);
    end

    // m + (m >> W) + v approximates m / (2^W - 1) so full-scale products round to full scale.
    function automatic logic [W-1:0] scale(input logic [MW-1:0] m, input logic [W-1:0] v);
        logic [MW:0] m2;
        m2 = {1'b0, m} + (MW+1)'(m >> W) + (MW+1)'(v);
        return m2[MW-1:TW];
    endfunction

    // Stage 3 combinational
    logic [W-1:0]  ch_d, ch_u, ch_r, ch_g, ch_b;
    logic [MW-1:0] rgb_d;

    always_comb begin
        ch_d = scale(md2_q, val2_q);
        ch_u = scale(mu2_q, val2_q);
        ch_r = '0;
        ch_g = '0;
        ch_b = '0;
        case (sx2_q)
            3'd0:    begin ch_r = val2_q; ch_g = ch_u;   end
            3'd1:    begin ch_r = ch_d;   ch_g = val2_q; end
            3'd2:    begin ch_g = val2_q; ch_b = ch_u;   end
            3'd3:    begin ch_g = ch_d;   ch_b = val2_q; end
            3'd4:    begin ch_r = ch_u;   ch_b = val2_q; end
            default: begin ch_r = val2_q; ch_b = ch_d;   end
        endcase
        rgb_d = grey2_q ? {val2_q, val2_q, val2_q} : {ch_r, ch_g, ch_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            vld3_q  <= 1'b0;
            rgb3_q  <= '0;
            user3_q <= '0;
        end else if (advance) begin
            vld1_q <= in_valid;
            vld2_q <= vld1_q;
            vld3_q <= vld2_q;
            if (in_valid) begin
                sx1_q   <= sx_d;
                sf1_q   <= sf_d;
                sfc1_q  <= sfc_d;
                val1_q  <= in_v;
                grey1_q <= (in_s == '0);
                user1_q <= in_user;
            end
            if (vld1_q) begin
                sx2_q   <= sx1_q;
                md2_q   <= md_d;
                mu2_q   <= mu_d;
                val2_q  <= val1_q;
                grey2_q <= grey1_q;
                user2_q <= user1_q;
            end
            if (vld2_q) begin
                rgb3_q  <= rgb_d;
                user3_q <= user2_q;
            end
        end
    end

endmodule

// File: doc/hsv2rgb_pipe.md
# hsv2rgb_pipe

Streaming, parametrised successor of the combinational HSV-to-RGB converter. It accepts one HSV pixel per cycle on a valid/ready input port and returns packed RGB on a valid/ready output port, with a fixed 3-stage pipeline, configurable channel width and a sideband tag carried alongside each pixel. It sits between pixel-generation logic (CFU op decode or a DMA front end) and the RGB consumer, and must sustain full throughput under backpressure.

## Interface
- `W`, 8: channel width in bits for S, V, hue fraction and each RGB channel; legal range 4..12.
- `USER_W`, 1: sideband tag width, passed through unchanged.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input pixel present.
- `in_ready` out 1: block accepts the input this cycle.
- `in_h` in W+8: hue; `[W+7:W]` = sextant, `[W-1:0]` = fraction f.
- `in_s` in W: saturation.
- `in_v` in W: value.
- `in_user` in USER_W: tag.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_rgb` out 3W: `{R,G,B}`, R in the MSBs.
- `out_user` out USER_W: tag of the pixel on `out_rgb`.

## Operation
- Arithmetic, per pixel. K = (2^W − 1)·2^W.
  - td = K − s·f; tu = K − s·(2^W − f); both 2W bits, never negative.
  - For t ∈ {td, tu}: m = v·t (3W bits); m2 = m + (m >> W) + v, computed at 3W+1 bits; result = m2[3W−1:2W].
  - d = result(td), falling ramp; u = result(tu), rising ramp.
- Sextant normalisation (sx): in_h[W+7:W] > 5 clamps to 5 (see Configuration).
- Channel select, unselected terms are 0:
  - R: v if sx ∈ {0,5}; d if sx = 1; u if sx = 4; 0 otherwise.
  - G: u if sx = 0; v if sx ∈ {1,2}; d if sx = 3; 0 otherwise.
  - B: u if sx = 2; v if sx ∈ {3,4}; d if sx = 5; 0 otherwise.
- If s = 0, all three channels equal v, regardless of hue.
- Pipeline stages:
  - S1 registers sx, s·f, s·(2^W − f), v, s==0 and tag.
  - S2 registers v·td and v·tu.
  - S3 registers the corrected, selected RGB and tag.
- Each stage holds a valid bit. Stages do not collapse bubbles; the pipeline advances as a unit.

## Timing
- advance = !v3 || out_ready, where v3 is the S3 valid bit.
- in_ready = advance, combinational from out_ready and v3.
- On advance:
  - v1 ← in_valid; v2 ← v1; v3 ← v2.
  - Data registers load only when the corresponding upstream valid is set.
- Stall (advance = 0): all stage registers hold; out_rgb and out_user stay stable while out_valid = 1.
- out_valid = v3.
- Latency: 3 cycles from an accepted input to out_valid, with out_ready held high.
- Throughput: 1 pixel per cycle with out_ready = 1.
- Transfers occur only when valid && ready on the same edge. An input offered while in_ready = 0 is not consumed and must be held by the source.
- Reset, including reset mid-stream:
  - v1, v2, v3 clear to 0, so out_valid = 0 and in-flight pixels are dropped.
  - out_rgb = 0, out_user = 0.
  - in_ready = 1 from the first cycle after reset.
- Simultaneous accept and emit in one cycle is legal and loses no data.

## Configuration
- `HSV2RGB_PIPE_HUE_WRAP_EN`
  - Defined: sx = sextant mod 6 (e.g. 7→1, 12→0). This lets hue counters run freely over the full sextant byte.
  - Undefined: sextant > 5 clamps to 5.
- Latency and throughput are identical in both builds.

## Test plan
All scenarios use W = 8.
- Reset check: assert reset with pixels in flight → out_valid = 0 and out_rgb = 0 the next cycle; no stale pixel is emitted after release.
- Primary hue: h = 0x0000, s = 0xFF, v = 0xFF, user = 1 → out_rgb = 0xFF0000, out_user = 1, exactly 3 cycles after acceptance.
- Mid-sextant rounding: h = 0x0080, s = 0xFF, v = 0xFF → out_rgb = 0xFF7F00.
- Grey path: s = 0x00, v = 0x40, any h → out_rgb = 0x404040.
- Out-of-range sextant: h = 0x0700, s = 0xFF, v = 0xFF → 0xFF00FF without the macro; 0xFFFF00 with `HSV2RGB_PIPE_HUE_WRAP_EN`.
- Backpressure and ordering: stream 100 random pixels with random in_valid and out_ready → in_ready = 0 whenever v3 && !out_ready; outputs match a reference model in order with no drops or duplicates; full-rate segments sustain 1 pixel per cycle.
